mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- Data-memory access stage sitting directly downstream of the main decoder.
- Consumes the decoder's memory-write, memory-read (write-data-select = memory) and 4-bit load/store select, plus the ALU-computed address and rt store data.
- Drives a variable-latency data memory through a req/ack handshake, stalls the core while the access is outstanding, and returns lane-extracted, sign/zero-extended load data.

Parameters:
- TIMEOUT_CYC, 255: maximum cycles in BUSY waiting for dm_ack before aborting with err; range 1..255.

Ports:
- clk  in  1  core clock
- rstn  in  1  synchronous active-low reset
- req_valid  in  1  current instruction is valid in this stage
- mem_rd  in  1  load instruction
- mem_wr  in  1  store instruction
- ld_sel  in  4  0=lw/sw, 1=lb, 2=lbu, 3=lh, 4=lhu, 5=sb, 6=sh
- addr  in  32  byte address from the ALU
- wdata  in  32  store data (rt)
- stall  out  1  hold PC/pipeline
- resp_valid  out  1  one-cycle pulse when the access completes
- rdata_out  out  32  extended load data, valid with resp_valid
- err  out  1  timeout or misalignment flag, valid with resp_valid
- dm_req  out  1  memory request, held until dm_ack
- dm_we  out  1  write enable
- dm_be  out  4  byte enables, little-endian
- dm_addr  out  32  word address {addr[31:2],2'b00}
- dm_wdata  out  32  lane-replicated store data
- dm_ack  in  1  memory completion, single-cycle pulse
- dm_rdata  in  32  read word, valid with dm_ack

Behaviour:
- Clocking and reset: single clock domain. Reset is synchronous and active-low on rstn.
- Reset values: state=IDLE, all dm_* outputs 0, resp_valid=0, rdata_out=0, err=0, counter=0.
- Reset mid-access: rstn low in any state returns to IDLE. A dm_ack arriving after reset is ignored.
- FSM has three states: IDLE, BUSY, DONE.
- IDLE, accept condition: an access is accepted when req_valid & (mem_rd|mem_wr).
- IDLE, on accept:
  - Latch ld_sel, addr[1:0] and the rd/wr kind.
  - Register dm_req=1, dm_we, dm_be, dm_addr and dm_wdata.
  - Go to BUSY.
  - stall=1 combinationally in the accept cycle.
- Conflicting kind: mem_rd & mem_wr both high is treated as a store.
- BUSY:
  - stall=1. All dm_* outputs are held stable. The counter increments every cycle.
  - On dm_ack: dm_req=0. For a load, register the extracted word into rdata_out (for a store, rdata_out=0). err=0. Go to DONE.
  - If the counter reaches TIMEOUT_CYC without dm_ack: dm_req=0, rdata_out=0, err=1, go to DONE.
- DONE:
  - resp_valid=1 and stall=0 for exactly one cycle; the core advances on this edge.
  - No new request is accepted in DONE.
  - Return to IDLE. resp_valid and err clear in IDLE.
- Latency: request accepted at cycle 0, dm_req high from cycle 1, dm_ack at cycle k≥1, resp_valid at cycle k+1. The minimum access is 3 cycles.
- Store byte lanes (off=addr[1:0]):
  - sb: be=4'b0001<<off, dm_wdata={4{wdata[7:0]}}.
  - sh: be=4'b0011<<{off[1],1'b0}, dm_wdata={2{wdata[15:0]}}.
  - Any other ld_sel with mem_wr: sw, be=4'b1111, dm_wdata=wdata.
- Loads: dm_be=4'b1111, dm_we=0.
  - lb/lbu select byte at off; lh/lhu select the half at off[1]; lb/lh sign-extend, lbu/lhu zero-extend.
  - ld_sel 0 or any value 5..15 with mem_rd returns the full word.
- Misaligned addresses without ALIGN_CHECK_EN:
  - Halfword at off[0]=1: off[0] is ignored.
  - Word: off is ignored.

Optional Feature:
- MEM_ACCESS_ALIGN_CHECK_EN defined:
  - Checked at accept: a halfword access with addr[0]=1, or a word access with addr[1:0]≠0, is misaligned.
  - A misaligned access issues no dm_req, goes IDLE→DONE directly with err=1 and rdata_out=0, and stalls for the accept cycle only.
- Macro undefined: no check; err is only ever set by timeout.

Decomposition:
- Shared package mem_access_pkg holds:
  - ld_sel encoding localparams: LS_W, LS_B, LS_BU, LS_H, LS_HU, LS_SB, LS_SH.
  - FSM state encoding.
- One combinational sub-module, load_extend (inputs dm_rdata, ld_sel, off; output 32-bit extended data), instantiated once.

Test Plan:
- sw at addr 0x0000_0010, wdata 0xDEADBEEF, ack after 2 cycles -> dm_be=1111, dm_addr=0x10, dm_we=1, resp_valid at cycle 3, err=0.
- lb at addr 0x13, dm_rdata=0x80FF_7F01 -> rdata_out=0xFFFF_FF80; lbu at the same address -> 0x0000_0080.
- lh at addr 0x22, dm_rdata=0x8001_0000 -> rdata_out=0xFFFF_8001; lhu -> 0x0000_8001.
- sb at addr 0x05, wdata 0x0000_00AB -> dm_be=0010, dm_wdata=0xABABABAB, dm_addr=0x04.
- Load with dm_ack never asserted, TIMEOUT_CYC=4 -> dm_req drops after 4 BUSY cycles, resp_valid=1, err=1, rdata_out=0.
- rstn low during BUSY, then a dm_ack pulse while in IDLE -> dm_req=0, no resp_valid, stall=0; with MEM_ACCESS_ALIGN_CHECK_EN, lw at 0x02 -> no dm_req, err=1 on resp_valid.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared encodings for the data-memory access stage: ld_sel codes and FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package mem_access_pkg;

    // ld_sel encoding driven by the main decoder
    localparam logic [3:0] LS_W  = 4'd0;
    localparam logic [3:0] LS_B  = 4'd1;
    localparam logic [3:0] LS_BU = 4'd2;
    localparam logic [3:0] LS_H  = 4'd3;
    localparam logic [3:0] LS_HU = 4'd4;
    localparam logic [3:0] LS_SB = 4'd5;
    localparam logic [3:0] LS_SH = 4'd6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Lane extraction and sign/zero extension of a returned memory word.
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
module load_extend
    import mem_access_pkg::*;
(
    input  logic [31:0] dm_rdata,
    input  logic [3:0]  ld_sel,
    input  logic [1:0]  off,
    output logic [31:0] ext_data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Pick the addressed byte/half, then extend according to the load flavour
    always_comb begin
        byte_v   = dm_rdata[8*off +: 8];
        half_v   = off[1] ? dm_rdata[31:16] : dm_rdata[15:0];
        ext_data = dm_rdata;
        case (ld_sel)
            LS_B:    ext_data = {{24{byte_v[7]}}, byte_v};
            LS_BU:   ext_data = {24'd0, byte_v};
            LS_H:    ext_data = {{16{half_v[15]}}, half_v};
            LS_HU:   ext_data = {16'd0, half_v};
            default: ext_data = dm_rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Data-memory access stage: issues one req/ack access per load/store and returns extended load data.
// Latency: accept cycle + BUSY until dm_ack (or TIMEOUT_CYC) + one DONE cycle; minimum 3 cycles.
// Backpressure: stall held from the accept cycle through BUSY; released in DONE. Optional MEM_ACCESS_ALIGN_CHECK_EN.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [3:0]  ld_sel,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        resp_valid,
    output logic [31:0] rdata_out,
    output logic        err,
    output logic        dm_req,
    output logic        dm_we,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata
);

    // Counter value on the last BUSY cycle allowed before aborting
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

    state_e      state_q;
    logic [7:0]  cnt_q;
    logic [3:0]  ld_sel_q;
    logic [1:0]  off_q;
    logic        is_wr_q;
    logic        dm_req_q, dm_we_q;
    logic [3:0]  dm_be_q;
    logic [31:0] dm_addr_q, dm_wdata_q;
    logic        resp_valid_q, err_q;
    logic [31:0] rdata_q;

    logic        accept;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic        misalign_d;
    logic [31:0] ext_data;

    assign accept = req_valid & (mem_rd | mem_wr);

    // Store lane steering; a store wins when rd and wr are both asserted
    always_comb begin
        be_d    = 4'b1111;
        wdata_d = wdata;
        if (mem_wr) begin
            case (ld_sel)
                LS_SB: begin
                    be_d    = 4'b0001 << addr[1:0];
                    wdata_d = {4{wdata[7:0]}};
                end
                LS_SH: begin
                    be_d    = 4'b0011 << {addr[1], 1'b0};
                    wdata_d = {2{wdata[15:0]}};
                end
                default: begin
                    be_d    = 4'b1111;
                    wdata_d = wdata;
                end
            endcase
        end
    end

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    logic half_acc, word_acc;

    // Classify the access size and flag addresses that do not fit it
    always_comb begin
        if (mem_wr) begin
            half_acc = (ld_sel == LS_SH);
            word_acc = (ld_sel != LS_SB) && (ld_sel != LS_SH);
        end else begin
            half_acc = (ld_sel == LS_H) || (ld_sel == LS_HU);
            word_acc = !((ld_sel == LS_B) || (ld_sel == LS_BU) || half_acc);
        end
        misalign_d = (half_acc && addr[0]) || (word_acc && (addr[1:0] != 2'b00));
    end
`else
    assign misalign_d = 1'b0;
`endif

    load_extend u_load_extend (
        .dm_rdata (dm_rdata),
        .ld_sel   (ld_sel_q),
        .off      (off_q),
        .ext_data (ext_data)
    );

    // Access sequencer: IDLE accepts, BUSY waits for ack or timeout, DONE pulses the response
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            ld_sel_q     <= '0;
            off_q        <= '0;
            is_wr_q      <= 1'b0;
            dm_req_q     <= 1'b0;
            dm_we_q      <= 1'b0;
            dm_be_q      <= '0;
            dm_addr_q    <= '0;
            dm_wdata_q   <= '0;
            resp_valid_q <= 1'b0;
            err_q        <= 1'b0;
            rdata_q      <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    resp_valid_q <= 1'b0;
                    err_q        <= 1'b0;
                    cnt_q        <= '0;
                    if (accept) begin
                        ld_sel_q <= ld_sel;
                        off_q    <= addr[1:0];
                        is_wr_q  <= mem_wr;
                        if (misalign_d) begin
                            // Never reaches memory; answer immediately with an error
                            resp_valid_q <= 1'b1;
                            err_q        <= 1'b1;
                            rdata_q      <= '0;
                            state_q      <= ST_DONE;
                        end else begin
                            dm_req_q   <= 1'b1;
                            dm_we_q    <= mem_wr;
                            dm_be_q    <= be_d;
                            dm_addr_q  <= {addr[31:2], 2'b00};
                            dm_wdata_q <= wdata_d;
                            state_q    <= ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    if (dm_ack) begin
                        dm_req_q     <= 1'b0;
                        rdata_q      <= is_wr_q ? 32'd0 : ext_data;
                        err_q        <= 1'b0;
                        resp_valid_q <= 1'b1;
                        state_q      <= ST_DONE;
                    end else if (cnt_q == TO_LAST) begin
                        dm_req_q     <= 1'b0;
                        rdata_q      <= '0;
                        err_q        <= 1'b1;
                        resp_valid_q <= 1'b1;
                        state_q      <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                ST_DONE: begin
                    resp_valid_q <= 1'b0;
                    err_q        <= 1'b0;
                    state_q      <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign stall      = (state_q == ST_BUSY) || ((state_q == ST_IDLE) && accept);
    assign resp_valid = resp_valid_q;
    assign rdata_out  = rdata_q;
    assign err        = err_q;
    assign dm_req     = dm_req_q;
    assign dm_we      = dm_we_q;
    assign dm_be      = dm_be_q;
    assign dm_addr    = dm_addr_q;
    assign dm_wdata   = dm_wdata_q;

endmodule
